wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Initiator side of the register-file write port: the single source of the regfile's we/waddr/wdata.
- Merges two producers onto that one write port:
  - the in-order MEM/WB pipeline write;
  - results from long-latency units (divider, multi-cycle multiply), which arrive on a valid/ready handshake.
- Long-latency results are held in a small FIFO and drained into idle write-port cycles.
- Exports a pending-write scoreboard so the decode stage can interlock.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_wreg_i  in  1  pipeline write request this cycle
- wb_wd_i  in  5  pipeline destination register
- wb_wdata_i  in  32  pipeline write data
- lu_valid_i  in  1  long-latency result valid
- lu_wd_i  in  5  long-latency destination register
- lu_wdata_i  in  32  long-latency result data
- lu_ready_o  out  1  FIFO can accept a result this cycle
- we_o  out  1  regfile write enable
- waddr_o  out  5  regfile write address
- wdata_o  out  32  regfile write data
- busy_o  out  32  bit n = 1: a FIFO entry targets register n
- stallreq_o  out  1  FIFO full; upstream must issue no pipeline write from the next cycle

Behaviour:
- Reset: synchronous, active-high; all state is cleared at a clk edge with rst=1.
  - FIFO emptied; count=0, rd_ptr=wr_ptr=0.
  - All outputs 0 while rst=1: we_o, waddr_o, wdata_o, busy_o, stallreq_o, lu_ready_o.
  - Reset mid-operation discards pending entries. No write is issued for them.
- Pipeline write is valid when wb_wreg_i=1 and wb_wd_i!=0. A write to r0 is treated as no write.
- Write-port selection is combinational, with 0-cycle latency for the pipeline:
  - valid pipeline write: we_o=1, waddr_o=wb_wd_i, wdata_o=wb_wdata_i; the FIFO does not pop;
  - else, FIFO non-empty: we_o=1, waddr/wdata = head entry; pop at the clk edge;
  - else: we_o=0, waddr_o=0, wdata_o=0.
- Handshake:
  - lu_ready_o = (count != DEPTH) && !rst.
  - An entry is pushed at the clk edge when lu_valid_i && lu_ready_o.
  - A producer holds lu_valid_i and its data stable until accepted.
  - lu_wd_i=0: the result is accepted but not pushed (dropped).
- Push and pop in the same cycle: count unchanged and both pointers advance. This is legal at any count < DEPTH; at DEPTH, ready=0, so no push occurs.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits wide.
- Ordering: FIFO entries are written to the regfile in acceptance order.
- busy_o:
  - OR of the one-hot decodes of all valid entries' addresses, from registered state only;
  - duplicate addresses remain busy until the last matching entry pops.
- The decode stage must stall any instruction reading or writing a busy register. This guarantees no WAW/RAW race between the pipeline and the FIFO. The arbiter does not check it.
- stallreq_o = (count == DEPTH). Registered-state based; no combinational path from lu_valid_i.
- A pipeline write arriving while stallreq_o=1 is still performed. Upstream stops issuing writes after one cycle.
- Starvation bound: with stallreq honoured, a full FIFO drains one entry per pipeline-idle cycle.

Optional Feature:
- Macro WB_LU_BYPASS_EN.
- Defined: when the FIFO is empty, no valid pipeline write is present and lu_valid_i=1 with lu_wd_i!=0:
  - the result goes straight to the write port in the same cycle (we_o=1, waddr_o=lu_wd_i, wdata_o=lu_wdata_i);
  - lu_ready_o=1 and nothing is pushed;
  - busy_o is not set for that register.
- Not defined: every long-latency result passes through the FIFO; earliest regfile write is the cycle after acceptance.

Test Plan:
- rst=1 for 2 cycles with lu_valid_i=1 and wb_wreg_i=1 → all outputs 0. After release, count=0 and lu_ready_o=1.
- Pipeline writes r3=0x0000_0005 while the FIFO is empty → we_o=1, waddr_o=3, wdata_o=5 in the same cycle. A pipeline write to r0 → we_o=0.
- Push lu r7=0xDEAD_BEEF while the pipeline writes r2 every cycle → busy_o[7]=1, FIFO holds the entry. On the first idle cycle: we_o=1, waddr_o=7, wdata_o=0xDEADBEEF. Next cycle busy_o=0.
- Push 4 results (r8..r11) with the pipeline busy → after the 4th, stallreq_o=1 and lu_ready_o=0; a 5th valid stays unaccepted. Pipeline idle → drains r8, r9, r10, r11 on consecutive cycles.
- FIFO at 3 entries, simultaneous push r12 and pop → count stays 3, order preserved. Wrap-around verified over 10 push/pop pairs.
- With WB_LU_BYPASS_EN: empty FIFO, idle pipeline, lu r5=0x1234 → same-cycle write, busy_o=0. Without the macro: write appears 1 cycle later and busy_o[5] is high for 1 cycle.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the MEM/WB pipeline write and buffered long-latency
// results onto the single regfile write port, and exports a pending-write mask.
// Ports: clk, rst (sync, active-high); wb_wreg_i/wb_wd_i/wb_wdata_i pipeline write;
// lu_valid_i/lu_wd_i/lu_wdata_i/lu_ready_o long-latency handshake;
// we_o/waddr_o/wdata_o regfile write port; busy_o pending-write mask;
// stallreq_o FIFO full.
// Optional macro WB_LU_BYPASS_EN: a long-latency result that finds the FIFO
// empty and the pipeline idle is written straight through in the same cycle.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wreg_i,
  input  logic [4:0]  wb_wd_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_wd_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] busy_o,
  output logic        stallreq_o
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             pipe_v, empty, byp, push, pop;
  logic [31:0]      busy;

  assign pipe_v     = wb_wreg_i && (wb_wd_i != 5'd0);
  assign empty      = count_q == '0;
  assign lu_ready_o = (count_q != FULL) && !rst;
  assign stallreq_o = (count_q == FULL) && !rst;
`ifdef WB_LU_BYPASS_EN
  assign byp = empty && !pipe_v && lu_valid_i && (lu_wd_i != 5'd0) && !rst;
`else
  assign byp = 1'b0;
`endif
  // r0 results are accepted (handshake completes) but never stored
  assign push    = lu_valid_i && lu_ready_o && (lu_wd_i != 5'd0) && !byp;
  assign pop     = !rst && !pipe_v && !empty;
  assign count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  // pipeline has priority; FIFO drains only into idle write-port cycles
  always_comb begin
    we_o    = !rst && (pipe_v || !empty || byp);
    waddr_o = rst ? 5'd0 : pipe_v ? wb_wd_i : !empty ? addr_q[rd_ptr_q] : byp ? lu_wd_i : 5'd0;
    wdata_o = rst ? 32'd0 : pipe_v ? wb_wdata_i : !empty ? data_q[rd_ptr_q] : byp ? lu_wdata_i : 32'd0;
  end

  // push and pop never target the same slot: that would need count==DEPTH
  always_comb begin
    vld_d = vld_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  // OR of every live entry's one-hot destination, so duplicates stay busy
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) busy[addr_q[i]] = 1'b1;
  end
  assign busy_o = rst ? 32'd0 : busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= lu_wd_i;
      data_q[wr_ptr_q] <= lu_wdata_i;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: queue-model scoreboard bench for wb_write_arbiter.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} ent_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wb_wreg = 1'b1, lu_valid = 1'b1;
  logic [4:0]  wb_wd = 5'd4, lu_wd = 5'd9;
  logic [31:0] wb_wdata = 32'h11, lu_wdata = 32'h22;
  logic        lu_ready, we, stallreq;
  logic [4:0]  waddr;
  logic [31:0] wdata, busy;

  ent_t q[$];
  int   total = 0, bad = 0;
  logic acc = 1'b0;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg_i(wb_wreg), .wb_wd_i(wb_wd), .wb_wdata_i(wb_wdata),
    .lu_valid_i(lu_valid), .lu_wd_i(lu_wd), .lu_wdata_i(lu_wdata),
    .lu_ready_o(lu_ready), .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .busy_o(busy), .stallreq_o(stallreq)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // compare every output against the queue model at negedge, then advance
  task automatic step();
    logic pv, byp, pop, ew;
    logic [4:0] ea;
    logic [31:0] ed, eb;
    @(negedge clk);
    pv  = wb_wreg && (wb_wd != 5'd0);
    byp = 1'b0;
`ifdef WB_LU_BYPASS_EN
    byp = !rst && q.size() == 0 && !pv && lu_valid && (lu_wd != 5'd0);
`endif
    eb = '0;
    foreach (q[i]) eb[q[i].a] = 1'b1;
    ew = 1'b0; ea = '0; ed = '0;
    if (rst) eb = '0;
    else if (pv) begin ew = 1'b1; ea = wb_wd; ed = wb_wdata; end
    else if (q.size() > 0) begin ew = 1'b1; ea = q[0].a; ed = q[0].d; end
    else if (byp) begin ew = 1'b1; ea = lu_wd; ed = lu_wdata; end
    chk("we", we, ew);
    chk("waddr", waddr, ea);
    chk("wdata", wdata, ed);
    chk("busy", busy, eb);
    chk("stallreq", stallreq, !rst && q.size() == DEPTH);
    chk("lu_ready", lu_ready, !rst && q.size() != DEPTH);
    if (rst) begin
      q.delete();
      acc = 1'b0;
    end else begin
      acc = lu_valid && q.size() != DEPTH;
      pop = !pv && q.size() > 0;
      if (pop) void'(q.pop_front());
      if (acc && lu_wd != 5'd0 && !byp) q.push_back('{a: lu_wd, d: lu_wdata});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(logic w, logic [4:0] a, logic [31:0] d);
    wb_wreg = w; wb_wd = a; wb_wdata = d;
  endtask

  task automatic set_lu(logic v, logic [4:0] a, logic [31:0] d);
    lu_valid = v; lu_wd = a; lu_wdata = d;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin step(); n++; end
    chk("drain_timeout", 32'(q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    step();
    step();
    rst = 1'b0;
    set_wb(0, 0, 0);
    set_lu(0, 0, 0);
    #1;
    chk("rel_ready", lu_ready, 1);
    chk("rel_stall", stallreq, 0);
    chk("rel_we", we, 0);
    step();

    set_wb(1, 3, 32'h5);
    #1;
    chk("r3_we", we, 1);
    chk("r3_addr", waddr, 3);
    chk("r3_data", wdata, 5);
    step();
    set_wb(1, 0, 32'h77);
    #1;
    chk("r0_we", we, 0);
    step();

    set_wb(1, 2, 32'hAAAA);
    set_lu(1, 7, 32'hDEADBEEF);
    step();
    chk("r7_acc", acc, 1);
    set_lu(0, 0, 0);
    chk("r7_busy", busy[7], 1);
    step();
    step();
    set_wb(0, 0, 0);
    #1;
    chk("r7_addr", waddr, 7);
    chk("r7_data", wdata, 32'hDEADBEEF);
    step();
    chk("r7_clear", busy, 0);

    set_wb(1, 2, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      set_lu(1, 5'(8 + i), 32'h100 + i);
      step();
    end
    set_lu(1, 12, 32'h200);
    #1;
    chk("full_stall", stallreq, 1);
    chk("full_ready", lu_ready, 0);
    step();
    chk("full_hold", acc, 0);
    set_wb(0, 0, 0);
    #1;
    chk("drain_first", waddr, 8);
    n = 0;
    do begin step(); n++; end while (!acc && n < 10);
    chk("r12_acc", acc, 1);
    set_lu(0, 0, 0);
    drain();

    set_wb(1, 2, 32'hCCCC);
    for (int i = 0; i < 3; i++) begin
      set_lu(1, 5'(13 + i), 32'h300 + i);
      step();
    end
    set_wb(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      set_lu(1, 5'(16 + i % 3), $urandom);
      #1;
      chk("pp_ready", lu_ready, 1);
      chk("pp_stall", stallreq, 0);
      step();
    end
    set_lu(0, 0, 0);
    drain();

    set_lu(1, 5, 32'h1234);
    #1;
`ifdef WB_LU_BYPASS_EN
    chk("byp_we", we, 1);
    chk("byp_addr", waddr, 5);
    chk("byp_busy", busy, 0);
    step();
    set_lu(0, 0, 0);
    #1;
    chk("byp_after", we, 0);
`else
    chk("nobyp_we", we, 0);
    step();
    set_lu(0, 0, 0);
    #1;
    chk("nobyp_busy", busy[5], 1);
    chk("nobyp_addr", waddr, 5);
    chk("nobyp_data", wdata, 32'h1234);
    step();
    chk("nobyp_clear", busy, 0);
`endif
    step();

    set_wb(1, 2, 32'hDDDD);
    set_lu(1, 20, 32'h400);
    step();
    set_lu(1, 21, 32'h401);
    step();
    set_lu(0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_wb(0, 0, 0);
    #1;
    chk("mrst_we", we, 0);
    chk("mrst_busy", busy, 0);
    step();

    for (int i = 0; i < 300; i++) begin
      set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if (!lu_valid || acc)
        set_lu(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
      step();
    end
    set_wb(0, 0, 0);
    set_lu(0, 0, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
